cnn_kernel_serial_mac: RTL and testbench
========================================

# cnn_kernel_serial_mac

Responder side of the kernel-request handshake issued by the channel-accumulation sequencer. Accepts one KX×KY input window plus its KX×KY weights on a single-cycle load pulse. Computes the signed dot product serially, one multiply-accumulate per clock. Returns the result with a single-cycle valid pulse; the initiator holds its state until that pulse arrives.

## Interface
- KX, default 3: kernel width.
- KY, default 3: kernel height.
- DATA_LEN, default 8: signed element, weight and result width.
- ACC_LEN, default 2*DATA_LEN+$clog2(KX*KY): internal accumulator width.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_soft_reset  in  1  synchronous clear; priority over all other inputs.
- i_in_valid  in  1  load request; sampled only when o_ready=1.
- i_cnn_weight  in  KX*KY*DATA_LEN  weights. Element k=ky*KX+kx sits at [k*DATA_LEN +: DATA_LEN]; row ky=0 occupies the low bits.
- i_in_fmap  in  KX*KY*DATA_LEN  window; same packing as i_cnn_weight.
- o_ready  out  1  high in IDLE; reset value 1.
- o_ot_valid  out  1  one-cycle result pulse; reset value 0.
- o_ot_kernel_acc  out  DATA_LEN  signed result, held until the next result; reset value 0.
- o_drop  out  1  one-cycle pulse when i_in_valid arrives while busy; reset value 0.

## Operation
- States: IDLE (o_ready=1) and MAC (o_ready=0).
- IDLE with i_in_valid=1:
  - capture both buses into internal registers;
  - clear acc and tap counter k;
  - go to MAC.
- IDLE with i_in_valid=0: stay in IDLE.
- MAC, each cycle: acc <= acc + sext(w[k])*sext(x[k]), full-precision signed product (2*DATA_LEN) extended to ACC_LEN; k increments.
- MAC at k==KX*KY-1:
  - final sum is acc plus the current product;
  - reduce final sum to DATA_LEN (see Configuration) and register it into o_ot_kernel_acc;
  - o_ot_valid <= 1 for one cycle;
  - return to IDLE.
- Input buses are not used after the capture cycle. The initiator may change them once i_in_valid has been accepted.
- i_in_valid in MAC: ignored; o_drop pulses the following cycle; computation continues unaffected.
- i_soft_reset=1: next edge forces IDLE and clears k, acc, o_ot_valid, o_drop and o_ot_kernel_acc to 0. A concurrent i_in_valid is dropped silently, with no o_drop pulse.
- reset asserted at any time, including mid-MAC: immediately forces IDLE and all outputs to their reset values. No o_ot_valid is produced for an interrupted window.
- k counts 0..KX*KY-1. It never wraps inside a transaction and is cleared on every accept.

## Timing
- Accept at edge E0, i.e. i_in_valid=1 and o_ready=1.
- MAC edges: E1..EN, with N=KX*KY (9 by default).
- o_ot_valid high in the cycle after EN. Latency from the accept edge is N edges.
- o_ready returns high in that same cycle. An i_in_valid in that cycle is accepted, so back-to-back throughput is one window per N+1 cycles.
- o_ot_kernel_acc updates at EN and is stable whenever o_ot_valid=1.
- o_drop is a registered pulse, one cycle after the offending i_in_valid.

## Configuration
- CNN_KERNEL_SAT_EN defined: the final sum is saturated to the signed DATA_LEN range, [-2^(DATA_LEN-1), 2^(DATA_LEN-1)-1].
- CNN_KERNEL_SAT_EN undefined: the final sum is truncated to its low DATA_LEN bits (two's-complement wrap).
- The accumulator itself never saturates in either build; ACC_LEN is sized so intermediate sums cannot overflow.

## Structure
- Shared header defines_cnn_core.vh holds:
  - KX, KY, DATA_LEN and the derived ACC_LEN;
  - IDLE/MAC state encodings;
  - tap-count constant KX*KY.
- One sub-module, cnn_mac_unit:
  - signed multiply, add into ACC_LEN;
  - final saturate/truncate under CNN_KERNEL_SAT_EN.
- The top block owns the FSM, tap counter, capture registers and handshake outputs.

## Test plan
- Weights all 1, window 1..9, single pulse -> o_ot_valid 9 edges after accept, o_ot_kernel_acc=45, o_ready low for exactly 9 cycles.
- Weights all -1, window all 127:
  - with CNN_KERNEL_SAT_EN -> result -128;
  - without CNN_KERNEL_SAT_EN -> result -119 (i.e. -1143 wrapped).
- Two windows back-to-back (second i_in_valid in the o_ot_valid cycle): results 45, then 0 (all-zero window), with o_ot_valid pulses 10 cycles apart.
- Second i_in_valid 3 cycles after accept -> o_drop pulse next cycle; first result still 45; no second o_ot_valid.
- i_soft_reset at MAC cycle 4 -> IDLE next cycle, o_ot_kernel_acc=0, no o_ot_valid; a following fresh window completes normally.
- reset asserted mid-MAC -> o_ready=1, o_ot_valid=0, o_ot_kernel_acc=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cnn_kernel_serial_mac_pkg.sv
// Shared definitions for the serial CNN kernel MAC: default geometry, FSM states, tap helpers.
// Result reduction mode is selected by CNN_KERNEL_SAT_EN (saturate) or its absence (truncate).
package cnn_kernel_serial_mac_pkg;

   localparam int unsigned DEF_KX       = 3;
   localparam int unsigned DEF_KY       = 3;
   localparam int unsigned DEF_DATA_LEN = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MAC  = 1'b1
   } state_t;

   function automatic int unsigned tap_count(input int unsigned kx, input int unsigned ky);
      return kx * ky;
   endfunction

   // Tap counter needs at least one bit even for a 1x1 kernel.
   function automatic int unsigned cnt_width(input int unsigned taps);
      return (taps > 1) ? $clog2(taps) : 1;
   endfunction

endpackage

// File: rtl/cnn_kernel_serial_mac_mac_unit.sv
// Single-tap signed multiply-accumulate with final DATA_LEN reduction.
// CNN_KERNEL_SAT_EN defined: saturate the result; undefined: two's-complement truncate.
module cnn_mac_unit
   import cnn_kernel_serial_mac_pkg::*;
#(
   parameter int unsigned DATA_LEN = DEF_DATA_LEN,
   parameter int unsigned ACC_LEN  = 2 * DEF_DATA_LEN + 4
) (
   input  logic [DATA_LEN-1:0] i_weight,
   input  logic [DATA_LEN-1:0] i_fmap,
   input  logic [ACC_LEN-1:0]  i_acc,
   output logic [ACC_LEN-1:0]  o_acc_next,
   output logic [DATA_LEN-1:0] o_result
);

   logic signed [2*DATA_LEN-1:0] product;
   logic signed [ACC_LEN-1:0]    product_ext;
   logic signed [ACC_LEN-1:0]    sum;

   assign product     = $signed(i_weight) * $signed(i_fmap);
   assign product_ext = ACC_LEN'(product);
   assign sum         = $signed(i_acc) + product_ext;
   assign o_acc_next  = sum;

`ifdef CNN_KERNEL_SAT_EN
   localparam logic signed [ACC_LEN-1:0] SAT_MAX =
      {{(ACC_LEN-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
   localparam logic signed [ACC_LEN-1:0] SAT_MIN =
      {{(ACC_LEN-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

   always_comb begin
      o_result = sum[DATA_LEN-1:0];
      if (sum > SAT_MAX) begin
         o_result = {1'b0, {(DATA_LEN-1){1'b1}}};
      end else if (sum < SAT_MIN) begin
         o_result = {1'b1, {(DATA_LEN-1){1'b0}}};
      end
   end
`else
   assign o_result = sum[DATA_LEN-1:0];
`endif

endmodule

// File: rtl/cnn_kernel_serial_mac.sv
// Serial KXxKY signed dot-product responder: capture on load pulse, one MAC per clock, valid pulse.
// Result reduction follows CNN_KERNEL_SAT_EN (saturate when defined, truncate otherwise).
module cnn_kernel_serial_mac
   import cnn_kernel_serial_mac_pkg::*;
#(
   parameter int unsigned KX       = DEF_KX,
   parameter int unsigned KY       = DEF_KY,
   parameter int unsigned DATA_LEN = DEF_DATA_LEN,
   parameter int unsigned ACC_LEN  = 2 * DATA_LEN + $clog2(KX * KY)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_soft_reset,
   input  logic                     i_in_valid,
   input  logic [KX*KY*DATA_LEN-1:0] i_cnn_weight,
   input  logic [KX*KY*DATA_LEN-1:0] i_in_fmap,
   output logic                     o_ready,
   output logic                     o_ot_valid,
   output logic [DATA_LEN-1:0]      o_ot_kernel_acc,
   output logic                     o_drop
);

   localparam int unsigned    TAPS   = tap_count(KX, KY);
   localparam int unsigned    K_W    = cnt_width(TAPS);
   localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

   state_t              state;
   state_t              state_nxt;
   logic [K_W-1:0]      k;
   logic [ACC_LEN-1:0]  acc;
   logic [ACC_LEN-1:0]  acc_nxt;
   logic [DATA_LEN-1:0] mac_result;
   logic [DATA_LEN-1:0] w_cap [TAPS];
   logic [DATA_LEN-1:0] x_cap [TAPS];
   logic                last_tap;
   logic                accept;

   assign last_tap = (k == K_LAST);
   assign accept   = (state == ST_IDLE) && i_in_valid && !i_soft_reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (i_soft_reset) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: if (i_in_valid) state_nxt = ST_MAC;
            ST_MAC:  if (last_tap)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_ready = (state == ST_IDLE);
   end

   // Buses are unpacked into per-tap registers so the MAC indexes by k directly.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned t = 0; t < TAPS; t++) begin
            w_cap[t] <= i_cnn_weight[t*DATA_LEN +: DATA_LEN];
            x_cap[t] <= i_in_fmap[t*DATA_LEN +: DATA_LEN];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k               <= '0;
         acc             <= '0;
         o_ot_valid      <= 1'b0;
         o_drop          <= 1'b0;
         o_ot_kernel_acc <= '0;
      end else begin
         o_ot_valid <= 1'b0;
         o_drop     <= 1'b0;
         if (i_soft_reset) begin
            k               <= '0;
            acc             <= '0;
            o_ot_kernel_acc <= '0;
         end else if (state == ST_IDLE) begin
            if (i_in_valid) begin
               k   <= '0;
               acc <= '0;
            end
         end else begin
            acc    <= acc_nxt;
            o_drop <= i_in_valid;
            if (last_tap) begin
               k               <= '0;
               o_ot_kernel_acc <= mac_result;
               o_ot_valid      <= 1'b1;
            end else begin
               k <= k + 1'b1;
            end
         end
      end
   end

   cnn_mac_unit #(
      .DATA_LEN (DATA_LEN),
      .ACC_LEN  (ACC_LEN)
   ) u_mac (
      .i_weight   (w_cap[k]),
      .i_fmap     (x_cap[k]),
      .i_acc      (acc),
      .o_acc_next (acc_nxt),
      .o_result   (mac_result)
   );

endmodule

// File: tb/tb_cnn_kernel_serial_mac.sv
// Directed bench for cnn_kernel_serial_mac with hand-computed results for both CNN_KERNEL_SAT_EN builds.
module tb_cnn_kernel_serial_mac;

   localparam int unsigned KX       = 3;
   localparam int unsigned KY       = 3;
   localparam int unsigned DATA_LEN = 8;
   localparam int unsigned BW       = KX * KY * DATA_LEN;

   logic                clk = 1'b0;
   logic                reset;
   logic                i_soft_reset;
   logic                i_in_valid;
   logic [BW-1:0]       i_cnn_weight;
   logic [BW-1:0]       i_in_fmap;
   logic                o_ready;
   logic                o_ot_valid;
   logic [DATA_LEN-1:0] o_ot_kernel_acc;
   logic                o_drop;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   cnn_kernel_serial_mac #(
      .KX       (KX),
      .KY       (KY),
      .DATA_LEN (DATA_LEN)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .i_soft_reset    (i_soft_reset),
      .i_in_valid      (i_in_valid),
      .i_cnn_weight    (i_cnn_weight),
      .i_in_fmap       (i_in_fmap),
      .o_ready         (o_ready),
      .o_ot_valid      (o_ot_valid),
      .o_ot_kernel_acc (o_ot_kernel_acc),
      .o_drop          (o_drop)
   );

   function automatic logic [BW-1:0] pack_const(input int v);
      logic [BW-1:0] b;
      for (int t = 0; t < KX * KY; t++) b[t*DATA_LEN +: DATA_LEN] = DATA_LEN'(v);
      return b;
   endfunction

   function automatic logic [BW-1:0] pack_ramp(input int base);
      logic [BW-1:0] b;
      for (int t = 0; t < KX * KY; t++) b[t*DATA_LEN +: DATA_LEN] = DATA_LEN'(base + t);
      return b;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int acc_now();
      return int'($signed(o_ot_kernel_acc));
   endfunction

   // Presents a window, lets the next edge accept it, then scrambles the buses.
   task automatic load(input logic [BW-1:0] w, input logic [BW-1:0] x);
      i_cnn_weight = w;
      i_in_fmap    = x;
      i_in_valid   = 1'b1;
      @(posedge clk);
      #1;
      i_in_valid   = 1'b0;
      i_cnn_weight = BW'({$urandom(), $urandom(), $urandom()});
      i_in_fmap    = BW'({$urandom(), $urandom(), $urandom()});
   endtask

   task automatic wait_valid(input int max_n, output int n, output int ready_low, output int res);
      n = -1;
      ready_low = 0;
      res = 0;
      for (int c = 1; c <= max_n; c++) begin
         @(negedge clk);
         if (!o_ready) ready_low++;
         if (o_ot_valid) begin
            n   = c;
            res = acc_now();
            break;
         end
      end
   endtask

   task automatic count_valids(input int cycles, output int v);
      v = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (o_ot_valid) v++;
      end
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n1, rl, res, res1, v;

      reset        = 1'b1;
      i_soft_reset = 1'b0;
      i_in_valid   = 1'b0;
      i_cnn_weight = '0;
      i_in_fmap    = '0;
      idle(2);
      check("rst_ready", int'(o_ready), 1);
      check("rst_valid", int'(o_ot_valid), 0);
      check("rst_acc", acc_now(), 0);
      check("rst_drop", int'(o_drop), 0);
      reset = 1'b0;
      idle(2);

      // ones . 1..9 = 45
      load(pack_const(1), pack_ramp(1));
      wait_valid(20, n, rl, res);
      check("t1_latency", n - 1, 9);
      check("t1_ready_low", rl, 9);
      check("t1_result", res, 45);
      check("t1_ready_back", int'(o_ready), 1);
      idle(1);
      check("t1_valid_single", int'(o_ot_valid), 0);
      check("t1_acc_held", acc_now(), 45);

      // back-to-back: second load in the valid cycle
      idle(2);
      load(pack_const(1), pack_ramp(1));
      wait_valid(20, n1, rl, res1);
      load(pack_const(1), pack_const(0));
      wait_valid(20, n, rl, res);
      check("b2b_first", res1, 45);
      check("b2b_second", res, 0);
      check("b2b_spacing", n, 10);

      // -1 x 127 nine times = -1143
      idle(2);
      load(pack_const(-1), pack_const(127));
      wait_valid(20, n, rl, res);
`ifdef CNN_KERNEL_SAT_EN
      check("neg_overflow", res, -128);
`else
      check("neg_overflow", res, -119);
`endif

      // 127 x 127 nine times = 145161
      idle(2);
      load(pack_const(127), pack_const(127));
      wait_valid(20, n, rl, res);
`ifdef CNN_KERNEL_SAT_EN
      check("pos_overflow", res, 127);
`else
      check("pos_overflow", res, 9);
`endif

      // (-4..4) . (1..9) = 60
      idle(2);
      load(pack_ramp(-4), pack_ramp(1));
      wait_valid(20, n, rl, res);
      check("mixed_sign", res, 60);

      // async reset mid-MAC, checked before any clock edge
      idle(2);
      load(pack_const(-1), pack_const(127));
      idle(3);
      #1;
      reset = 1'b1;
      #1;
      check("arst_ready", int'(o_ready), 1);
      check("arst_valid", int'(o_ot_valid), 0);
      check("arst_acc", acc_now(), 0);
      @(negedge clk);
      reset = 1'b0;
      count_valids(15, v);
      check("arst_no_valid", v, 0);

      // load while busy -> drop pulse, computation unaffected
      load(pack_const(1), pack_ramp(1));
      idle(3);
      i_in_valid = 1'b1;
      i_in_fmap  = pack_const(5);
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      @(negedge clk);
      check("drop_pulse", int'(o_drop), 1);
      @(negedge clk);
      check("drop_single", int'(o_drop), 0);
      wait_valid(20, n, rl, res);
      check("drop_result", res, 45);
      count_valids(15, v);
      check("drop_no_second", v, 0);

      // soft reset in MAC cycle 4 with a concurrent load
      load(pack_const(1), pack_ramp(1));
      idle(4);
      i_soft_reset = 1'b1;
      i_in_valid   = 1'b1;
      @(posedge clk);
      #1;
      i_soft_reset = 1'b0;
      i_in_valid   = 1'b0;
      @(negedge clk);
      check("srst_ready", int'(o_ready), 1);
      check("srst_acc", acc_now(), 0);
      check("srst_drop", int'(o_drop), 0);
      count_valids(15, v);
      check("srst_no_valid", v, 0);

      // fresh window after soft reset: 2..10 = 54
      load(pack_const(1), pack_ramp(2));
      wait_valid(20, n, rl, res);
      check("srst_fresh_latency", n - 1, 9);
      check("srst_fresh_result", res, 54);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
